// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a small FIFO toward decode.
// Optional feature: define IFU_MISALIGN_CHECK_EN for per-entry misalign flags and fetch halt on misaligned redirects.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_SIZE = 32,
    parameter int unsigned          BUF_DEPTH = 2,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = 32'h80000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [ADDR_SIZE-1:0] imem_rdata,
    output logic                 id_valid,
    output logic [ADDR_SIZE-1:0] id_pc,
    output logic [ADDR_SIZE-1:0] id_instr,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic                 id_misalign,
`endif
    input  logic                 id_ready
);

    localparam int unsigned          PTR_W   = (BUF_DEPTH > 2) ? 2 : 1;
    localparam logic [PTR_W:0]       DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);
    localparam logic [ADDR_SIZE-1:0] PC_STEP = ADDR_SIZE'(4);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t               r_state, w_state_nxt;
    logic [ADDR_SIZE-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [ADDR_SIZE-1:0] r_pend_pc;
    logic [ADDR_SIZE-1:0] w_redirect_pc;
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic [ADDR_SIZE-1:0] r_buf_pc    [BUF_DEPTH];
    logic [ADDR_SIZE-1:0] r_buf_instr [BUF_DEPTH];
    logic                 w_flush, w_push, w_pop, w_grant, w_req, w_valid, w_stall;

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_halt;
    logic r_buf_mis [BUF_DEPTH];

    assign w_redirect_pc = redirect_pc;
    assign w_stall       = r_halt;

    // A misaligned target parks fetch until a later redirect supplies a usable one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_halt <= 1'b0;
        else if (redirect)
            r_halt <= (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_buf_mis[r_wr_ptr] <= (r_pend_pc[1:0] != 2'b00);
    end

    assign id_misalign = w_valid ? r_buf_mis[r_rd_ptr] : 1'b0;
`else
    assign w_redirect_pc = redirect_pc & ~ADDR_SIZE'(3);
    assign w_stall       = 1'b0;
`endif

    assign w_valid   = (r_count != '0);
    assign w_req     = (r_state == REQ) && (r_count < DEPTH_C) && !w_stall;
    assign w_pop     = w_valid && id_ready && !w_flush;
    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_flush        = 1'b0;
        w_push         = 1'b0;
        w_grant        = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                if (redirect)
                    w_fetch_pc_nxt = w_redirect_pc;
            end
            REQ: begin
                if (redirect) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_pc;
                end else if (w_req && imem_gnt) begin
                    w_grant        = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
                    w_state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_state_nxt    = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            DROP: begin
                if (redirect)
                    w_fetch_pc_nxt = w_redirect_pc;
                if (imem_rvalid)
                    w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_grant)
                r_pend_pc <= r_fetch_pc;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]    <= r_pend_pc;
            r_buf_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    assign id_valid = w_valid;
    assign id_pc    = w_valid ? r_buf_pc[r_rd_ptr]    : '0;
    assign id_instr = w_valid ? r_buf_instr[r_rd_ptr] : '0;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_SIZE, default 32, address and instruction width in bits.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; legal values 2 or 4.
REQ-003 Parameter RESET_PC, default 32'h80000000, first fetch address.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 redirect  input  1  taken branch or jump; new fetch stream begins.
REQ-007 redirect_pc  input  ADDR_SIZE  target address, sampled when redirect=1.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  ADDR_SIZE  fetch address.
REQ-010 imem_gnt  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  response data valid; at most one per granted request, at least 1 cycle after grant.
REQ-012 imem_rdata  input  ADDR_SIZE  fetched instruction.
REQ-013 id_valid  output  1  instruction available to decode.
REQ-014 id_pc  output  ADDR_SIZE  PC of the presented instruction.
REQ-015 id_instr  output  ADDR_SIZE  presented instruction.
REQ-016 id_ready  input  1  decode consumes the head entry when id_valid=1 and id_ready=1.
REQ-017 id_misalign  output  1  head entry PC is not 4-byte aligned (present only with IFU_MISALIGN_CHECK_EN).

Function
REQ-018 States: IDLE, REQ, WAIT, DROP. IDLE occurs only after reset.
REQ-019 IDLE -> REQ on the first clock edge after reset deasserts.
REQ-020 In REQ, imem_req=1 when buffer occupancy is below BUF_DEPTH; imem_addr=fetch_pc.
REQ-021 Address stability: imem_addr and imem_req hold until granted, except when redirect changes the address.
REQ-022 REQ -> WAIT on imem_req & imem_gnt; fetch_pc <= fetch_pc + 4; granted PC is latched as pend_pc.
REQ-023 WAIT -> REQ on imem_rvalid; {pend_pc, imem_rdata} is pushed into the buffer in the same edge.
REQ-024 At most one request is outstanding; imem_req=0 in IDLE, WAIT and DROP.
REQ-025 Buffer: BUF_DEPTH-entry FIFO, wrap-around pointers, count 0..BUF_DEPTH. id_* reflect the head; id_valid = (count != 0).
REQ-026 Push and pop in the same cycle leave the count unchanged. A push when full cannot occur, because of REQ-020.
REQ-027 Zero bypass: a response is first visible on id_* one cycle after imem_rvalid.
REQ-028 Redirect in REQ: fetch_pc <= redirect_pc and the buffer is flushed. Remains in REQ; a same-cycle grant is ignored.
REQ-029 Redirect in WAIT without imem_rvalid: go to DROP, fetch_pc <= redirect_pc, flush the buffer.
REQ-030 Redirect in WAIT with imem_rvalid: discard the response, go to REQ, fetch_pc <= redirect_pc, flush the buffer.
REQ-031 DROP: discard the next imem_rvalid response, then go to REQ. A redirect in DROP only updates fetch_pc.
REQ-032 Flush has priority over a same-cycle pop or push; count <= 0.
REQ-033 Redirect in IDLE: fetch_pc <= redirect_pc; normal IDLE -> REQ transition.
REQ-034 fetch_pc arithmetic is modulo 2^ADDR_SIZE; 0xFFFFFFFC + 4 wraps to 0.

Reset
REQ-035 When reset asserts, the following take effect immediately:
- state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0
- imem_req=0, id_valid=0, id_pc=0, id_instr=0, id_misalign=0
REQ-036 Reset mid-transaction abandons any outstanding request. A response arriving within 1 cycle after reset release is ignored (the block is in IDLE).

Configuration
REQ-037 Macro IFU_MISALIGN_CHECK_EN.
- Defined: each entry stores a misalign bit = (pc[1:0] != 0), driven on id_misalign.
- Defined: a misaligned redirect_pc still loads fetch_pc, but the block issues no request until the next redirect.
- Undefined: id_misalign port is absent; redirect_pc[1:0] is forced to 0.

Verification
REQ-038 Reset release, gnt=1 always, rvalid 1 cycle after grant, id_ready=1 -> imem_addr 0x80000000, 0x80000004, ...; id_pc follows each address 2 cycles after its grant.
REQ-039 id_ready=0, BUF_DEPTH=2 -> two responses buffered, then imem_req=0. id_ready=1 for one cycle -> imem_req=1 the next cycle.
REQ-040 Redirect to 0x80000100 while in WAIT, rvalid 3 cycles later with data 0xDEADBEEF -> data never appears on id_*; next imem_addr=0x80000100.
REQ-041 Redirect in the same cycle as rvalid and id pop, count=1 -> count=0, next id_pc=redirect target, no stale entry.
REQ-042 Async reset asserted mid-WAIT -> outputs zero immediately; after release, first imem_addr=0x80000000.
REQ-043 With IFU_MISALIGN_CHECK_EN, redirect to 0x80000102 -> imem_req stays 0; a redirect to 0x80000200 resumes fetch.
